// File: rtl/kyber_pkg.sv
// -----------------------------------------------------------------------------
// kyber_pkg
// Shared definitions for the Kyber NTT datapath.
//   - mode_e      : pass modes driven on the address generator's mode input
//   - N/BFLY/NLAYER and derived widths for the 256-coefficient transform
//   - bfly_addr_t : one butterfly's read pair plus its twiddle index
//   - bfly_addr() : maps (mode, layer, butterfly index) to bfly_addr_t
// -----------------------------------------------------------------------------
package kyber_pkg;

  typedef enum logic [1:0] {
    NTT  = 2'b00,
    INTT = 2'b01,
    IN   = 2'b10,
    OUT  = 2'b11
  } mode_e;

  localparam int N      = 256;         // coefficients per polynomial
  localparam int BFLY   = N / 2;       // butterflies (address pairs) per pass
  localparam int NLAYER = 7;           // butterfly layers per transform
  localparam int AW     = $clog2(N);   // coefficient address width
  localparam int IW     = $clog2(BFLY); // butterfly index / twiddle width

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [IW-1:0] tw;
  } bfly_addr_t;

  // Butterfly i of a layer belongs to group g = i / len and sits at offset
  // j = i % len inside it; groups are 2*len coefficients apart. len is a
  // power of two, so the divide/modulo collapse to a shift and a mask.
  function automatic bfly_addr_t bfly_addr(input mode_e      mode,
                                           input logic [2:0] layer,
                                           input logic [6:0] i);
    bfly_addr_t r;
    logic [2:0] sh;   // log2(len)
    logic [7:0] len;
    logic [6:0] g;
    logic [6:0] j;
    logic [7:0] a;
    r   = '0;
    sh  = '0;
    len = '0;
    g   = '0;
    j   = '0;
    a   = '0;
    if (mode == NTT || mode == INTT) begin
      // Forward layers halve the span (128 -> 2); inverse layers double it.
      sh  = (mode == NTT) ? 3'd7 - layer : layer + 3'd1;
      len = 8'd1 << sh;
      g   = i >> sh;
      j   = i & (len[6:0] - 7'd1);
      a   = ({1'b0, g} << ({1'b0, sh} + 4'd1)) | {1'b0, j};
      r.a = a;
      r.b = a + len;
      if (mode == NTT) r.tw = (7'd1 << layer) + g;
      else             r.tw = 7'((8'd128 >> layer) - 8'd1 - {1'b0, g});
    end else begin
      // Load/unload sweeps walk the coefficients as consecutive pairs.
      r.a = {i, 1'b0};
      r.b = {i, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_addr_gen_if.sv
// -----------------------------------------------------------------------------
// ntt_addr_gen_if
// Control/address bundle between the NTT address generator and the
// coefficient memory / butterfly datapath.
//   master (generator): in  mode, newloop, wen
//                       out rd_addr_a/b, rd_valid, tw_idx, wr_addr_a/b,
//                           layer, crt_sig, busy, err
//   slave  (datapath) : the mirror image
// -----------------------------------------------------------------------------
interface ntt_addr_gen_if;

  logic [1:0] mode;       // 00 NTT, 01 INTT, 10 IN, 11 OUT
  logic       newloop;    // one-cycle pulse: start a pass
  logic       wen;        // one-cycle write strobe: consume one write pair
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic       rd_valid;
  logic [6:0] tw_idx;
  logic [7:0] wr_addr_a;  // head of the write-address queue
  logic [7:0] wr_addr_b;
  logic [2:0] layer;
  logic       crt_sig;    // final write of the pass
  logic       busy;
  logic       err;        // sticky: wen seen with nothing queued

  modport master (
    input  mode, newloop, wen,
    output rd_addr_a, rd_addr_b, rd_valid, tw_idx,
           wr_addr_a, wr_addr_b, layer, crt_sig, busy, err
  );

  modport slave (
    output mode, newloop, wen,
    input  rd_addr_a, rd_addr_b, rd_valid, tw_idx,
           wr_addr_a, wr_addr_b, layer, crt_sig, busy, err
  );

endinterface

// File: rtl/addr_fifo.sv
// -----------------------------------------------------------------------------
// addr_fifo
// Synchronous FIFO holding write-address pairs while their butterflies are
// in flight. Push and pop may share a cycle, including when full.
//   clk, rst : clock, synchronous active-high reset
//   flush    : empty the queue (discards all entries)
//   push/din : enqueue din (ignored when full unless a pop happens too)
//   pop      : dequeue the head (ignored when empty)
//   dout     : head entry, meaningful only while !empty
//   full/empty
// -----------------------------------------------------------------------------
module addr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this very cycle, so a full queue still takes a push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; empty gates every
  // read of it, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/ntt_addr_gen.sv
// -----------------------------------------------------------------------------
// ntt_addr_gen
// Address generator for an in-place 256-point NTT/INTT. Each pass issues
// 128 butterfly read pairs (with twiddle index) and queues the matching
// write pairs until the datapath writes them back.
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset (aborts a pass silently)
//   bus  : ntt_addr_gen_if.master -- mode/newloop/wen in; read pair,
//          rd_valid, tw_idx, queue head, layer, crt_sig, busy, err out
// Parameters
//   WB_LAT : read-issue to earliest wen for the same butterfly (sizing)
//   QDEPTH : write-address queue depth, power of two
// -----------------------------------------------------------------------------
module ntt_addr_gen
  import kyber_pkg::*;
#(
  parameter int WB_LAT = 12,
  parameter int QDEPTH = 16
) (
  input logic           clk,
  input logic           rst,
  ntt_addr_gen_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e        state;
  state_e        state_nxt;
  mode_e         mode_q;
  logic [2:0]    layer_q;
  logic [6:0]    idx;       // butterfly index i
  logic [6:0]    pop_cnt;   // write pairs consumed this pass
  logic          err_q;

  logic          issue;
  logic          crt;
  logic          flush;
  logic          pop_ok;
  logic          last_issue;
  bfly_addr_t    addr;

  logic          q_full;
  logic          q_empty;
  logic [15:0]   q_head;

  // A queue shorter than the write-back latency cannot cover every pair in
  // flight, so issue would throttle below one pair per cycle.
  if (QDEPTH < WB_LAT) begin : g_queue_shallower_than_wb_lat
  end

  assign pop_ok     = bus.wen && !q_empty;
  assign last_issue = (idx == 7'(BFLY - 1));
  assign addr       = bfly_addr(mode_q, layer_q, idx);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    state_nxt = state;
    issue     = 1'b0;
    crt       = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.newloop) state_nxt = ISSUE;
      end
      ISSUE: begin
        // OUT never sees wen, so it must not stall on a full queue; the
        // queue just saturates and is flushed when the sweep ends.
        issue = (mode_q == OUT) || !q_full || pop_ok;
        if (issue && last_issue) begin
          if (mode_q == OUT) begin
            crt       = 1'b1;
            flush     = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop_ok && pop_cnt == 7'(BFLY - 1)) begin
          crt       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= NTT;
      layer_q <= '0;
      idx     <= '0;
      pop_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.newloop) begin
        mode_q  <= mode_e'(bus.mode);
        idx     <= '0;
        pop_cnt <= '0;
      end
      if (issue) idx <= idx + 7'd1;
      if (pop_ok && state != IDLE) pop_cnt <= pop_cnt + 7'd1;
      if (bus.wen && q_empty) err_q <= 1'b1;
      if (crt && (mode_q == NTT || mode_q == INTT))
        layer_q <= (layer_q == 3'(NLAYER - 1)) ? 3'd0 : layer_q + 3'd1;
    end
  end

  addr_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (16)
  ) u_wr_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (issue),
    .din   ({addr.a, addr.b}),
    .pop   (bus.wen),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // Read-side outputs are forced to zero outside an issue cycle so idle
  // and post-reset outputs are all zero.
  assign bus.rd_valid  = issue;
  assign bus.rd_addr_a = issue ? addr.a  : '0;
  assign bus.rd_addr_b = issue ? addr.b  : '0;
  assign bus.tw_idx    = issue ? addr.tw : '0;
  assign bus.wr_addr_a = q_empty ? '0 : q_head[15:8];
  assign bus.wr_addr_b = q_empty ? '0 : q_head[7:0];
  assign bus.layer     = layer_q;
  assign bus.crt_sig   = crt;
  assign bus.busy      = (state != IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_ntt_addr_gen
// Self-checking bench for ntt_addr_gen. A behavioural model (pass flag,
// issued/popped counts, a queue of pending write pairs, address arithmetic
// straight from the len/g/j formulas) predicts every output each cycle;
// directed passes pin the model with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_ntt_addr_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_addr_gen_if bus ();

  ntt_addr_gen #(.WB_LAT(12), .QDEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit chk_en = 1'b0;
  bit m_busy;
  int m_mode, m_layer, m_issued, m_pops;
  bit m_err;
  int m_q[$];
  int cap_a[128], cap_b[128], cap_tw[128];
  int cnt_rv = 0, cnt_crt = 0;

  function automatic void model_reset();
    m_busy = 0; m_mode = 0; m_layer = 0; m_issued = 0; m_pops = 0; m_err = 0;
    m_q.delete();
  endfunction

  function automatic void model_addr(input int md, input int ly, input int i,
                                     output int a, output int b, output int tw);
    int len, g, j;
    if (md == 0 || md == 1) begin
      len = (md == 0) ? (128 >> ly) : (2 << ly);
      g   = i / len;
      j   = i % len;
      a   = g * 2 * len + j;
      b   = a + len;
      tw  = (md == 0) ? (1 << ly) + g : (128 >> ly) - 1 - g;
    end else begin
      a = 2 * i; b = 2 * i + 1; tw = 0;
    end
  endfunction

  always @(negedge clk) begin : cmp
    bit issuing, full, empty, pop_ok, exp_rv, exp_crt, was_busy;
    int ea, eb, etw, ewa, ewb;
    if (chk_en) begin
      issuing = m_busy && m_issued < 128;
      full    = m_q.size() == 16;
      empty   = m_q.size() == 0;
      pop_ok  = bus.wen && !empty;
      exp_rv  = issuing && (m_mode == 3 || !full || pop_ok);
      ea = 0; eb = 0; etw = 0;
      if (exp_rv) model_addr(m_mode, m_layer, m_issued, ea, eb, etw);
      ewa = empty ? 0 : m_q[0] / 256;
      ewb = empty ? 0 : m_q[0] % 256;
      exp_crt = m_busy && ((m_mode == 3) ? (exp_rv && m_issued == 127)
                                         : (pop_ok && m_pops == 127));

      check("rd_valid",  bus.rd_valid,  exp_rv);
      check("rd_addr_a", bus.rd_addr_a, ea);
      check("rd_addr_b", bus.rd_addr_b, eb);
      check("tw_idx",    bus.tw_idx,    etw);
      check("wr_addr_a", bus.wr_addr_a, ewa);
      check("wr_addr_b", bus.wr_addr_b, ewb);
      check("layer",     bus.layer,     m_layer);
      check("crt_sig",   bus.crt_sig,   exp_crt);
      check("busy",      bus.busy,      m_busy);
      check("err",       bus.err,       m_err);

      if (bus.rd_valid === 1'b1) cnt_rv++;
      if (bus.crt_sig === 1'b1) cnt_crt++;
      if (exp_rv) begin
        cap_a[m_issued]  = bus.rd_addr_a;
        cap_b[m_issued]  = bus.rd_addr_b;
        cap_tw[m_issued] = bus.tw_idx;
      end

      if (rst) begin
        model_reset();
      end else begin
        was_busy = m_busy;
        if (pop_ok) begin
          void'(m_q.pop_front());
          if (m_busy) m_pops++;
        end
        if (exp_rv && m_q.size() < 16) m_q.push_back(ea * 256 + eb);
        if (bus.wen && empty) m_err = 1;
        if (exp_rv) m_issued++;
        if (exp_crt) begin
          m_busy = 0;
          if (m_mode < 2) m_layer = (m_layer + 1) % 7;
          if (m_mode == 3) m_q.delete();
        end
        if (!was_busy && bus.newloop) begin
          m_busy = 1; m_mode = bus.mode; m_issued = 0; m_pops = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit nl, input bit w);
    bus.newloop = nl;
    bus.wen     = w;
    step();
    bus.newloop = 1'b0;
    bus.wen     = 1'b0;
  endtask

  // period > 0: wen every period cycles; otherwise wen with pct% chance.
  task automatic run_pass(input int md, input int period, input int pct,
                          input bit spam, input int budget);
    int cyc;
    bit w, nl;
    bus.mode = 2'(md);
    drive(1'b1, 1'b0);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < budget) begin
      w  = (md != 3) && (m_q.size() > 0) &&
           ((period > 0) ? (cyc % period == period - 1) : ($urandom_range(99) < pct));
      nl = spam && ($urandom_range(15) == 0);
      if (nl) bus.mode = 2'($urandom_range(3));
      drive(nl, w);
      cyc++;
    end
    check("pass_done", bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int c0, r0, cyc;
    rst = 1'b1; bus.mode = 2'b00; bus.newloop = 1'b0; bus.wen = 1'b0;
    model_reset();
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    check("reset_busy",     bus.busy,      0);
    check("reset_rd_valid", bus.rd_valid,  0);
    check("reset_layer",    bus.layer,     0);
    check("reset_err",      bus.err,       0);
    check("reset_wr_a",     bus.wr_addr_a, 0);

    // NTT layer 0, wen every 15 cycles.
    c0 = cnt_crt;
    run_pass(0, 15, 0, 1'b0, 3000);
    check("ntt0_first_a",  cap_a[0],   0);
    check("ntt0_first_b",  cap_b[0],   128);
    check("ntt0_first_tw", cap_tw[0],  1);
    check("ntt0_last_a",   cap_a[127], 127);
    check("ntt0_last_b",   cap_b[127], 255);
    check("ntt0_crt",      cnt_crt - c0, 1);
    check("ntt0_layer",    bus.layer,  1);

    // Layers 1..5 with random write-back and ignored newloop pulses.
    for (int l = 1; l < 6; l++) run_pass(0, 0, 85, 1'b1, 2000);
    check("ntt_layer6_pre", bus.layer, 6);

    // NTT layer 6.
    run_pass(0, 0, 85, 1'b0, 2000);
    check("ntt6_first_a",  cap_a[0],    0);
    check("ntt6_first_b",  cap_b[0],    2);
    check("ntt6_first_tw", cap_tw[0],   64);
    check("ntt6_last_a",   cap_a[127],  253);
    check("ntt6_last_b",   cap_b[127],  255);
    check("ntt6_last_tw",  cap_tw[127], 127);
    check("ntt6_wrap",     bus.layer,   0);

    // INTT layer 0.
    run_pass(1, 0, 85, 1'b0, 2000);
    check("intt0_i0_a",    cap_a[0],    0);
    check("intt0_i0_b",    cap_b[0],    2);
    check("intt0_i0_tw",   cap_tw[0],   127);
    check("intt0_i1_a",    cap_a[1],    1);
    check("intt0_i1_b",    cap_b[1],    3);
    check("intt0_i1_tw",   cap_tw[1],   127);
    check("intt0_i2_a",    cap_a[2],    4);
    check("intt0_i2_b",    cap_b[2],    6);
    check("intt0_i2_tw",   cap_tw[2],   126);
    check("intt0_last_a",  cap_a[127],  253);
    check("intt0_last_b",  cap_b[127],  255);
    check("intt0_last_tw", cap_tw[127], 64);
    check("intt0_layer",   bus.layer,   1);

    // IN: no wen for 40 cycles, then full-queue push+pop, then drain.
    c0 = cnt_crt;
    bus.mode = 2'b10;
    drive(1'b1, 1'b0);
    r0 = cnt_rv;
    repeat (40) drive(1'b0, 1'b0);
    check("in_stall_issues", cnt_rv - r0, 16);
    for (int k = 0; k < 8; k++) begin
      check("in_head_a", bus.wr_addr_a, 2 * k);
      check("in_head_b", bus.wr_addr_b, 2 * k + 1);
      bus.wen = 1'b1;
      #1;
      check("full_push_pop_rv", bus.rd_valid, 1);
      step();
      bus.wen = 1'b0;
    end
    r0 = cnt_rv;
    repeat (3) drive(1'b0, 1'b0);
    check("full_still_stalled", cnt_rv - r0, 0);
    check("full_head_a", bus.wr_addr_a, 16);
    check("full_head_b", bus.wr_addr_b, 17);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 400) begin
      drive(1'b0, m_q.size() > 0);
      cyc++;
    end
    check("in_done",  bus.busy,     0);
    check("in_crt",   cnt_crt - c0, 1);
    check("in_layer", bus.layer,    1);

    // OUT: no wen at all, ends on the 128th issue.
    c0 = cnt_crt;
    r0 = cnt_rv;
    run_pass(3, 0, 0, 1'b1, 400);
    check("out_issues", cnt_rv - r0, 128);
    check("out_crt",    cnt_crt - c0, 1);
    check("out_layer",  bus.layer,  1);
    check("out_flush_a", bus.wr_addr_a, 0);

    // Reset at i=50 in the middle of an NTT pass.
    bus.mode = 2'b00;
    drive(1'b1, 1'b0);
    cyc = 0;
    while (m_issued < 50 && cyc < 500) begin
      drive(1'b0, (m_q.size() > 0) && ($urandom_range(3) != 0));
      cyc++;
    end
    check("rst_mid_busy", bus.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_rd_valid", bus.rd_valid,  0);
    check("rst_rd_a",     bus.rd_addr_a, 0);
    check("rst_rd_b",     bus.rd_addr_b, 0);
    check("rst_tw",       bus.tw_idx,    0);
    check("rst_wr_a",     bus.wr_addr_a, 0);
    check("rst_wr_b",     bus.wr_addr_b, 0);
    check("rst_layer",    bus.layer,     0);
    check("rst_crt",      bus.crt_sig,   0);
    check("rst_busy",     bus.busy,      0);
    check("rst_err",      bus.err,       0);
    c0 = cnt_crt;
    repeat (20) drive(1'b0, 1'b0);
    check("rst_no_crt", cnt_crt - c0, 0);
    run_pass(0, 0, 80, 1'b0, 2000);
    check("restart_a",  cap_a[0],  0);
    check("restart_b",  cap_b[0],  128);
    check("restart_tw", cap_tw[0], 1);

    // Random passes in random modes.
    for (int p = 0; p < 4; p++)
      run_pass(int'($urandom_range(3)), 0, int'($urandom_range(95, 40)), 1'b1, 2000);

    // wen on an empty queue sets the sticky error flag.
    drive(1'b0, 1'b1);
    check("err_set", bus.err, 1);
    repeat (5) drive(1'b0, 1'b0);
    check("err_sticky", bus.err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
